lcd_bus_sequencer: RTL and testbench

- Parametrised HD44780-style LCD bus driver: takes one command byte per valid/ready handshake and drives LCD_D, LCD_RS, LCD_RW and LCD_E.
- Supports an 8-bit bus or a 4-bit bus (two nibble transfers per byte, or one upper-nibble-only transfer for init).
- Setup, E-high and hold times are derived from the clock frequency.
- Sits between the LCD init/text controller FSM and the board pins; replaces the single-nibble, fixed-timing transfer block.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_cycle_timer.sv | 27 ++
 rtl/lcd_bus_sequencer.sv | 157 +++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and elaboration-time helpers for the HD44780-style LCD bus sequencer.
// Phase lengths are computed once here so every sequencer instance agrees on them.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      E_HIGH,
      HOLD,
      DELAY
   } lcd_state_e;

   // Whole cycles per microsecond times the phase length, never shorter than one cycle.
   function automatic int cycles_from_us(input longint freq_hz, input int us);
      longint c;
      c = (freq_hz / 64'd1000000) * us;
      return (c < 1) ? 1 : int'(c);
   endfunction

   function automatic bit bus_width_ok(input int w);
      return (w == 4) || (w == 8);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter shared by every sequencer phase.
// start loads the number of remaining cycles minus one; expired is high once it reaches zero.
module lcd_cycle_timer #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 bus driver: one command byte per handshake, 4- or 8-bit bus, clock-derived
// setup / E-high / hold timing followed by a per-command post-delay.
module lcd_bus_sequencer
   import lcd_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BUS_WIDTH   = 4,
   parameter int SETUP_US    = 1,
   parameter int E_HIGH_US   = 3,
   parameter int HOLD_US     = 1,
   parameter int DELAY_W     = 21
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_rs,
   input  logic [7:0]           cmd_data,
   input  logic                 cmd_nibble_only,
   input  logic [DELAY_W-1:0]   cmd_delay,
   output logic [BUS_WIDTH-1:0] LCD_D,
   output logic                 LCD_RS,
   output logic                 LCD_RW,
   output logic                 LCD_E,
   output logic                 cmd_done,
   output logic                 busy
);

   localparam int SETUP_CYC = cycles_from_us(CLK_FREQ_HZ, SETUP_US);
   localparam int E_CYC     = cycles_from_us(CLK_FREQ_HZ, E_HIGH_US);
   localparam int HOLD_CYC  = cycles_from_us(CLK_FREQ_HZ, HOLD_US);
   localparam int CNT_W     = $clog2(max3(max3(SETUP_CYC, E_CYC, HOLD_CYC), 2**DELAY_W, 2));

   generate
      if (!bus_width_ok(BUS_WIDTH)) begin : g_bad_width
         $error("lcd_bus_sequencer: BUS_WIDTH must be 4 or 8");
      end
   endgenerate

   lcd_state_e           state, state_n;
   logic [BUS_WIDTH-1:0] lcd_d_n;
   logic                 lcd_rs_n, lcd_e_n, done_n;
   logic [3:0]           cap_lo, cap_lo_n;
   logic                 lo_pend, lo_pend_n;
   logic [DELAY_W-1:0]   cap_delay, cap_delay_n;
   logic                 tmr_start, tmr_exp;
   logic [CNT_W-1:0]     tmr_val;

   lcd_cycle_timer #(.W(CNT_W)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .start    (tmr_start),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   assign cmd_ready = (state == IDLE) && !RST;
   assign busy      = (state != IDLE);
   assign LCD_RW    = 1'b0;

   always_comb begin
      state_n     = state;
      lcd_d_n     = LCD_D;
      lcd_rs_n    = LCD_RS;
      lcd_e_n     = LCD_E;
      done_n      = 1'b0;
      cap_lo_n    = cap_lo;
      lo_pend_n   = lo_pend;
      cap_delay_n = cap_delay;
      tmr_start   = 1'b0;
      tmr_val     = '0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               // 4-bit bus takes the upper nibble first; 8-bit takes the whole byte
               lcd_d_n     = BUS_WIDTH'(cmd_data >> (8 - BUS_WIDTH));
               lcd_rs_n    = cmd_rs;
               cap_lo_n    = cmd_data[3:0];
               lo_pend_n   = (BUS_WIDTH == 4) && !cmd_nibble_only;
               cap_delay_n = cmd_delay;
               tmr_start   = 1'b1;
               tmr_val     = CNT_W'(SETUP_CYC - 1);
               state_n     = SETUP;
            end
         end
         SETUP: begin
            if (tmr_exp) begin
               lcd_e_n   = 1'b1;
               tmr_start = 1'b1;
               tmr_val   = CNT_W'(E_CYC - 1);
               state_n   = E_HIGH;
            end
         end
         E_HIGH: begin
            if (tmr_exp) begin
               lcd_e_n   = 1'b0;
               tmr_start = 1'b1;
               tmr_val   = CNT_W'(HOLD_CYC - 1);
               state_n   = HOLD;
            end
         end
         HOLD: begin
            if (tmr_exp) begin
               if (lo_pend) begin
                  lcd_d_n   = BUS_WIDTH'(cap_lo);
                  lo_pend_n = 1'b0;
                  tmr_start = 1'b1;
                  tmr_val   = CNT_W'(SETUP_CYC - 1);
                  state_n   = SETUP;
               end else begin
                  lcd_d_n  = '0;
                  lcd_rs_n = 1'b0;
                  // A zero delay contributes no cycles, so completion lands on this edge
                  if (cap_delay == '0) begin
                     done_n  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     tmr_start = 1'b1;
                     tmr_val   = CNT_W'(cap_delay - 1'b1);
                     state_n   = DELAY;
                  end
               end
            end
         end
         DELAY: begin
            if (tmr_exp) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         LCD_D     <= '0;
         LCD_RS    <= 1'b0;
         LCD_E     <= 1'b0;
         cmd_done  <= 1'b0;
         cap_lo    <= '0;
         lo_pend   <= 1'b0;
         cap_delay <= '0;
      end else begin
         state     <= state_n;
         LCD_D     <= lcd_d_n;
         LCD_RS    <= lcd_rs_n;
         LCD_E     <= lcd_e_n;
         cmd_done  <= done_n;
         cap_lo    <= cap_lo_n;
         lo_pend   <= lo_pend_n;
         cap_delay <= cap_delay_n;
      end
   end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench for lcd_bus_sequencer: three instances (8-bit, 4-bit, 8-bit slow clock)
// driven with random commands; expected E pulses and completion times come from the timing rules.
module tb_lcd_bus_sequencer;

   localparam int N = 3;

   typedef struct packed {
      int         rise;
      logic [7:0] d;
      logic       rs;
   } xfer_t;

   logic        CLK = 1'b0;
   logic        rst       [N];
   logic        cmd_valid [N];
   logic        cmd_rs    [N];
   logic        cmd_nib   [N];
   logic [7:0]  cmd_data  [N];
   logic [20:0] cmd_delay [N];
   logic        ready [N];
   logic        rs_o  [N];
   logic        rw_o  [N];
   logic        e_o   [N];
   logic        done  [N];
   logic        busy  [N];
   logic [7:0]  d8_0, d8_2;
   logic [3:0]  d4_1;

   int    cyc = 0;
   int    vectors = 0;
   int    miscompares = 0;
   xfer_t xq [N][$];
   int    dq [N][$];
   xfer_t cur [N];
   logic  e_prev [N];

   initial forever #5 CLK = ~CLK;
   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   lcd_bus_sequencer #(.CLK_FREQ_HZ(50000000), .BUS_WIDTH(8)) u_b8 (
      .CLK(CLK), .RST(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(ready[0]),
      .cmd_rs(cmd_rs[0]), .cmd_data(cmd_data[0]), .cmd_nibble_only(cmd_nib[0]),
      .cmd_delay(cmd_delay[0]), .LCD_D(d8_0), .LCD_RS(rs_o[0]), .LCD_RW(rw_o[0]),
      .LCD_E(e_o[0]), .cmd_done(done[0]), .busy(busy[0]));

   lcd_bus_sequencer #(.CLK_FREQ_HZ(50000000), .BUS_WIDTH(4)) u_b4 (
      .CLK(CLK), .RST(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(ready[1]),
      .cmd_rs(cmd_rs[1]), .cmd_data(cmd_data[1]), .cmd_nibble_only(cmd_nib[1]),
      .cmd_delay(cmd_delay[1]), .LCD_D(d4_1), .LCD_RS(rs_o[1]), .LCD_RW(rw_o[1]),
      .LCD_E(e_o[1]), .cmd_done(done[1]), .busy(busy[1]));

   lcd_bus_sequencer #(.CLK_FREQ_HZ(500000), .BUS_WIDTH(8)) u_slow (
      .CLK(CLK), .RST(rst[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(ready[2]),
      .cmd_rs(cmd_rs[2]), .cmd_data(cmd_data[2]), .cmd_nibble_only(cmd_nib[2]),
      .cmd_delay(cmd_delay[2]), .LCD_D(d8_2), .LCD_RS(rs_o[2]), .LCD_RW(rw_o[2]),
      .LCD_E(e_o[2]), .cmd_done(done[2]), .busy(busy[2]));

   function automatic int bus_w(input int i);
      return (i == 1) ? 4 : 8;
   endfunction

   function automatic int phase(input int i, input int us);
      int f;
      int c;
      f = (i == 2) ? 500000 : 50000000;
      c = (f / 1000000) * us;
      return (c < 1) ? 1 : c;
   endfunction

   function automatic logic [7:0] lcd_d(input int i);
      case (i)
         0:       return d8_0;
         1:       return {4'h0, d4_1};
         default: return d8_2;
      endcase
   endfunction

   task automatic chk(input int i, input string what, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL inst%0d %s: got %0d, expected %0d", i, what, act, exp);
      end
   endtask

   // Expected pulses/completion for a command accepted on the coming edge
   task automatic push_cmd(input int i);
      int a, t, n;
      xfer_t x;
      a = cyc + 1;
      t = phase(i, 1) + phase(i, 3) + phase(i, 1);
      if (bus_w(i) == 8) begin
         n = 1;
         x = '{rise: a + phase(i, 1), d: cmd_data[i], rs: cmd_rs[i]};
         xq[i].push_back(x);
      end else begin
         n = cmd_nib[i] ? 1 : 2;
         x = '{rise: a + phase(i, 1), d: {4'h0, cmd_data[i][7:4]}, rs: cmd_rs[i]};
         xq[i].push_back(x);
         if (n == 2) begin
            x = '{rise: a + t + phase(i, 1), d: {4'h0, cmd_data[i][3:0]}, rs: cmd_rs[i]};
            xq[i].push_back(x);
         end
      end
      dq[i].push_back(a + n * t + int'(cmd_delay[i]));
   endtask

   task automatic run_inst(input int i, input int ncmd);
      int issued;
      int guard;
      issued = 0;
      guard  = 0;
      while (issued < ncmd && guard < 20000) begin
         @(negedge CLK);
         guard++;
         // first few commands keep valid high so back-to-back acceptance is exercised
         cmd_valid[i] = (issued < 3) || ($urandom_range(0, 3) != 0);
         cmd_data[i]  = 8'($urandom);
         cmd_rs[i]    = 1'($urandom);
         cmd_nib[i]   = 1'($urandom);
         cmd_delay[i] = ($urandom_range(0, 3) == 0) ? 21'd0 : 21'($urandom_range(1, 15));
         if (issued == 0 && i == 0) begin
            cmd_data[i] = 8'hA5; cmd_rs[i] = 1'b1; cmd_nib[i] = 1'b0; cmd_delay[i] = 21'd100;
         end
         if (issued == 0 && i == 1) begin
            cmd_data[i] = 8'h3C; cmd_rs[i] = 1'b0; cmd_nib[i] = 1'b0; cmd_delay[i] = 21'd0;
         end
         if (issued == 1 && i == 1) begin
            cmd_data[i] = 8'h30; cmd_rs[i] = 1'b0; cmd_nib[i] = 1'b1; cmd_delay[i] = 21'd10;
         end
         if (issued == 0 && i == 2) cmd_delay[i] = 21'd0;
         if (cmd_valid[i] && ready[i]) begin
            push_cmd(i);
            issued++;
         end
      end
      chk(i, "commands_accepted_in_budget", issued, ncmd);
      @(negedge CLK);
      cmd_valid[i] = 1'b0;
   endtask

   task automatic abort_test();
      int g;
      g = 0;
      @(negedge CLK);
      while (!ready[1] && g < 2000) begin
         @(negedge CLK);
         g++;
      end
      chk(1, "ready_before_abort", ready[1], 1);
      cmd_valid[1] = 1'b1; cmd_data[1] = 8'h5A; cmd_rs[1] = 1'b1;
      cmd_nib[1]   = 1'b0; cmd_delay[1] = 21'd5;
      push_cmd(1);
      @(negedge CLK);
      cmd_valid[1] = 1'b0;
      g = 0;
      while (!e_o[1] && g < 2000) begin
         @(negedge CLK);
         g++;
      end
      chk(1, "e_high_before_abort", e_o[1], 1);
      repeat (20) @(negedge CLK);
      #2 rst[1] = 1'b1;
      #1;
      chk(1, "e_async_drop", e_o[1], 0);
      chk(1, "reset_mid_outputs", {lcd_d(1), rs_o[1], done[1], busy[1], ready[1]}, 0);
      xq[1].delete();
      dq[1].delete();
      repeat (3) @(negedge CLK);
      chk(1, "ready_low_in_reset", ready[1], 0);
      rst[1] = 1'b0;
   endtask

   // Monitor: compares every E edge and every completion pulse against the scoreboard
   initial begin
      xfer_t x;
      for (int i = 0; i < N; i++) e_prev[i] = 1'b0;
      forever begin
         @(negedge CLK);
         for (int i = 0; i < N; i++) begin
            if (!rst[i]) begin
               if (e_o[i] && !e_prev[i]) begin
                  if (xq[i].size() == 0) begin
                     chk(i, "unexpected_e_rise", 1, 0);
                  end else begin
                     x = xq[i].pop_front();
                     cur[i] = x;
                     chk(i, "e_rise_cycle", cyc, x.rise);
                     chk(i, "lcd_d_at_rise", lcd_d(i), x.d);
                     chk(i, "lcd_rs_at_rise", rs_o[i], x.rs);
                  end
               end
               if (!e_o[i] && e_prev[i]) begin
                  chk(i, "e_fall_cycle", cyc, cur[i].rise + phase(i, 3));
                  chk(i, "lcd_d_at_fall", lcd_d(i), cur[i].d);
               end
               if (done[i]) begin
                  if (dq[i].size() == 0) begin
                     chk(i, "unexpected_cmd_done", 1, 0);
                  end else begin
                     chk(i, "cmd_done_cycle", cyc, dq[i].pop_front());
                     chk(i, "idle_at_done", {lcd_d(i), rs_o[i], rw_o[i], busy[i], ready[i]}, 1);
                  end
               end
            end
            e_prev[i] = e_o[i];
         end
      end
   end

   initial begin
      int g;
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_rs[i] = 1'b0; cmd_nib[i] = 1'b0;
         cmd_data[i] = '0; cmd_delay[i] = '0;
      end
      repeat (3) @(negedge CLK);
      for (int i = 0; i < N; i++)
         chk(i, "reset_outputs", {lcd_d(i), rs_o[i], e_o[i], done[i], busy[i], ready[i]}, 0);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      fork
         run_inst(0, 12);
         begin
            run_inst(1, 6);
            abort_test();
            run_inst(1, 4);
         end
         run_inst(2, 40);
      join
      g = 0;
      while ((dq[0].size() + dq[1].size() + dq[2].size()) != 0 && g < 5000) begin
         @(negedge CLK);
         g++;
      end
      for (int i = 0; i < N; i++) begin
         chk(i, "pending_completions", dq[i].size(), 0);
         chk(i, "pending_e_pulses", xq[i].size(), 0);
      end
      repeat (2) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
